// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus types plus the arbiter FSM state encoding.
package mem_bus_arbiter_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memreq;

  typedef struct packed {
    logic [31:0] data;
  } memresp;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory-bus link: a request pulse one way, a response pulse back.
// Handshake: request_enable and response_enable are single-cycle pulses with no
// ready/backpressure; each payload is valid only in the cycle its enable is high.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic   request_enable;
  memreq  request;
  logic   response_enable;
  memresp response;

  modport master (
    output request_enable, request,
    input  response_enable, response
  );

  modport slave (
    input  request_enable, request,
    output response_enable, response
  );
endinterface

// File: rtl/mem_arb_slot.sv
// One-deep pending request buffer for a single client, with outstanding tracking.
module mem_arb_slot
  import mem_bus_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_en,
  input  memreq req,
  input  logic  grant,
  input  logic  resp_en,
  output logic  valid,
  output memreq slot_req,
  output logic  drop
);

  logic outstanding;
  logic accept;

  // The response cycle itself already frees the port for a new request.
  assign accept = req_en && (!outstanding || resp_en);
  assign drop   = req_en && outstanding && !resp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= 1'b0;
      outstanding <= 1'b0;
      slot_req    <= '0;
    end else if (accept) begin
      valid       <= 1'b1;
      outstanding <= 1'b1;
      slot_req    <= req;
    end else begin
      if (grant)   valid       <= 1'b0;
      if (resp_en) outstanding <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin sharing of one memory bus between fetch (c0) and mem stage (c1).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   c0,
  mem_bus_arbiter_if.slave   c1,
  mem_bus_arbiter_if.master  bus,
  output logic               busy,
  output logic               timeout,
  output logic               err,
  output arb_state_t         state
);

  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t               state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     req_en_q, req_en_d;
  memreq                    req_q, req_d;
  logic [1:0]               resp_en_q, resp_en_d;
  memresp                   r0_q, r0_d, r1_q, r1_d;
  logic                     timeout_q, timeout_d;
  logic                     err_q, err_d;

  logic  v0, v1, drop0, drop1, grant0, grant1, pick;
  memreq sreq0, sreq1;

  mem_arb_slot u_slot0 (
    .clk(clk), .rst(rst), .req_en(c0.request_enable), .req(c0.request),
    .grant(grant0), .resp_en(resp_en_q[0]),
    .valid(v0), .slot_req(sreq0), .drop(drop0)
  );

  mem_arb_slot u_slot1 (
    .clk(clk), .rst(rst), .req_en(c1.request_enable), .req(c1.request),
    .grant(grant1), .resp_en(resp_en_q[1]),
    .valid(v1), .slot_req(sreq1), .drop(drop1)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_en_d  = 1'b0;
    req_d     = req_q;
    resp_en_d = 2'b00;
    r0_d      = r0_q;
    r1_d      = r1_q;
    timeout_d = 1'b0;
    err_d     = err_q | drop0 | drop1;
    grant0    = 1'b0;
    grant1    = 1'b0;
    pick      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.response_enable) err_d = 1'b1;
        if (v0 || v1) begin
          // On a tie the port that did not win last time goes first.
          pick     = (v0 && v1) ? ~last_q : v1;
          grant0   = ~pick;
          grant1   = pick;
          req_d    = pick ? sreq1 : sreq0;
          req_en_d = 1'b1;
          owner_d  = pick;
          last_d   = pick;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.response_enable) begin
          resp_en_d[owner_q] = 1'b1;
          if (owner_q) r1_d = bus.response;
          else         r0_d = bus.response;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          resp_en_d[owner_q] = 1'b1;
          if (owner_q) r1_d = '0;
          else         r0_d = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      req_en_q  <= 1'b0;
      req_q     <= '0;
      resp_en_q <= 2'b00;
      r0_q      <= '0;
      r1_q      <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      req_en_q  <= req_en_d;
      req_q     <= req_d;
      resp_en_q <= resp_en_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.request_enable = req_en_q;
  assign bus.request        = req_q;
  assign c0.response_enable = resp_en_q[0];
  assign c0.response        = r0_q;
  assign c1.response_enable = resp_en_q[1];
  assign c1.response        = r1_q;
  assign busy               = (state_q == WAIT);
  assign timeout            = timeout_q;
  assign err                = err_q;
  assign state              = state_q;

endmodule
